pip_stage_chain: RTL

Pipeline stage register chain that consumes the 6-bit stall vector and flush pulse from the pipeline controller. It applies hold, bubble and flush semantics to a PC/valid tag carried through six stages: PC, IF, ID, EX, MEM and WB. It also generates the next fetch PC, with sequential, branch-redirect and exception-redirect sources. It sits between the pipeline controller and the datapath stage registers, and is the single authority on which stage holds a live instruction.

---
 rtl/pip_stage_chain.sv | 101 ++++++++++
 1 files changed

// File: rtl/pip_stage_chain.sv
// Six-stage PC/valid tag chain (PC, IF, ID, EX, MEM, WB) with hold, bubble, flush and branch squash.
// Optional `PIP_PERF_CNT_EN adds retire_cnt / bubble_cnt performance counters.
module pip_stage_chain #(
   parameter logic [31:0] RESET_PC = 32'h1c00_0000
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [5:0]   stall,
   input  logic         flush,
   input  logic [31:0]  flush_pc,
   input  logic         br_taken,
   input  logic [31:0]  br_target,
   output logic [5:0]   stage_valid,
   output logic [191:0] stage_pc,
   output logic [31:0]  fetch_pc,
   output logic         retire_valid,
`ifdef PIP_PERF_CNT_EN
   output logic [31:0]  retire_cnt,
   output logic [31:0]  bubble_cnt,
`endif
   output logic [31:0]  retire_pc
);

   logic [31:0] pc_q [6];
   logic [31:0] pc_d [6];
   logic [5:0]  valid_q;
   logic [5:0]  valid_d;
   logic        br_go;

   assign br_go = br_taken & ~stall[2];

   always_comb begin
      for (int unsigned i = 0; i < 6; i++) pc_d[i] = pc_q[i];
      valid_d = valid_q;
      if (flush) begin
         pc_d[0]      = flush_pc;
         valid_d      = 6'b000001;
      end else begin
         if (!stall[0]) begin
            pc_d[0]    = br_go ? br_target : pc_q[0] + 32'd4;
            valid_d[0] = 1'b1;
         end
         for (int unsigned i = 1; i < 6; i++) begin
            if (!stall[i]) begin
               // IF and ID hold wrong-path work when a branch redirects; squash them
               if (stall[i-1] || (br_go && i < 3)) begin
                  valid_d[i] = 1'b0;
               end else begin
                  pc_d[i]    = pc_q[i-1];
                  valid_d[i] = valid_q[i-1];
               end
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pc_q[0] <= RESET_PC;
         for (int unsigned i = 1; i < 6; i++) pc_q[i] <= '0;
         valid_q <= 6'b000001;
      end else begin
         for (int unsigned i = 0; i < 6; i++) pc_q[i] <= pc_d[i];
         valid_q <= valid_d;
      end
   end

   always_comb begin
      stage_pc = '0;
      for (int unsigned i = 0; i < 6; i++) stage_pc[32*i +: 32] = pc_q[i];
   end

   assign stage_valid  = valid_q;
   assign fetch_pc     = pc_q[0];
   assign retire_pc    = pc_q[5];
   assign retire_valid = valid_q[5] & ~stall[5];

`ifdef PIP_PERF_CNT_EN
   logic [31:0] retire_cnt_q, retire_cnt_d;
   logic [31:0] bubble_cnt_q, bubble_cnt_d;

   always_comb begin
      retire_cnt_d = retire_cnt_q + {31'd0, retire_valid};
      bubble_cnt_d = bubble_cnt_q + {31'd0, ~valid_q[5] & ~stall[5]};
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         retire_cnt_q <= '0;
         bubble_cnt_q <= '0;
      end else begin
         retire_cnt_q <= retire_cnt_d;
         bubble_cnt_q <= bubble_cnt_d;
      end
   end

   assign retire_cnt = retire_cnt_q;
   assign bubble_cnt = bubble_cnt_q;
`endif

endmodule
